// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared 1080p60 raster constants, pattern codes and colour-bar palette
package video_timing_pkg;
    localparam int HR  = 1920;
    localparam int HFP = 88;
    localparam int HSW = 44;
    localparam int HBP = 148;
    localparam int VR  = 1080;
    localparam int VFP = 4;
    localparam int VSW = 5;
    localparam int VBP = 36;
    localparam int HT  = HR + HFP + HSW + HBP;
    localparam int VT  = VR + VFP + VSW + VBP;
    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GREY  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;
    localparam logic [23:0] WHITE   = 24'hFFFFFF;
    localparam logic [23:0] YELLOW  = 24'hFFFF00;
    localparam logic [23:0] CYAN    = 24'h00FFFF;
    localparam logic [23:0] GREEN   = 24'h00FF00;
    localparam logic [23:0] MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RED     = 24'hFF0000;
    localparam logic [23:0] BLUE    = 24'h0000FF;
    localparam logic [23:0] BLACK   = 24'h000000;
    // index 0 is the leftmost bar
    localparam logic [7:0][23:0] BAR_COLOURS = {BLACK, BLUE, RED, MAGENTA, GREEN, CYAN, YELLOW, WHITE};
endpackage

// File: rtl/raster_counter.sv
// raster_counter: free-running h/v raster counters with active, hsync and vsync decode
module raster_counter #(
    parameter int HR  = video_timing_pkg::HR,
    parameter int HFP = video_timing_pkg::HFP,
    parameter int HSW = video_timing_pkg::HSW,
    parameter int HBP = video_timing_pkg::HBP,
    parameter int VR  = video_timing_pkg::VR,
    parameter int VFP = video_timing_pkg::VFP,
    parameter int VSW = video_timing_pkg::VSW,
    parameter int VBP = video_timing_pkg::VBP
) (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] h_cnt,
    output logic [11:0] v_cnt,
    output logic        active,
    output logic        hsync,
    output logic        vsync
);
    localparam logic [11:0] H_LAST = 12'(HR + HFP + HSW + HBP - 1);
    localparam logic [11:0] V_LAST = 12'(VR + VFP + VSW + VBP - 1);
    logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 12'd1;
        v_cnt_d = (h_cnt_q != H_LAST) ? v_cnt_q : (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 12'd1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end
    assign h_cnt  = h_cnt_q;
    assign v_cnt  = v_cnt_q;
    assign active = h_cnt_q < 12'(HR) && v_cnt_q < 12'(VR);
    assign hsync  = h_cnt_q >= 12'(HR + HFP) && h_cnt_q < 12'(HR + HFP + HSW);
    assign vsync  = v_cnt_q >= 12'(VR + VFP) && v_cnt_q < 12'(VR + VFP + VSW);
endmodule

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster timing source with selectable test pattern and registered outputs
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int HR  = video_timing_pkg::HR,
    parameter int HFP = video_timing_pkg::HFP,
    parameter int HSW = video_timing_pkg::HSW,
    parameter int HBP = video_timing_pkg::HBP,
    parameter int VR  = video_timing_pkg::VR,
    parameter int VFP = video_timing_pkg::VFP,
    parameter int VSW = video_timing_pkg::VSW,
    parameter int VBP = video_timing_pkg::VBP
) (
    input  logic       pix_1x_clk,
    input  logic       reset_in,
    input  logic [1:0] pattern_sel,
    output logic       de,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic [7:0] red_out,
    output logic [7:0] green_out,
    output logic [7:0] blue_out
);
    logic [11:0] h_cnt, v_cnt;
    logic        active, hsync_c, vsync_c, origin;
    logic [2:0]  bar;
    logic [23:0] pix;
    pattern_e    sel_q, sel_d;
    logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, frame_start_q, frame_start_d;
    logic [23:0] rgb_q, rgb_d;
    raster_counter #(
        .HR(HR), .HFP(HFP), .HSW(HSW), .HBP(HBP),
        .VR(VR), .VFP(VFP), .VSW(VSW), .VBP(VBP)
    ) u_raster (
        .clk(pix_1x_clk),
        .rst(reset_in),
        .h_cnt(h_cnt),
        .v_cnt(v_cnt),
        .active(active),
        .hsync(hsync_c),
        .vsync(vsync_c)
    );
    // the pixel at (0,0) already uses the newly latched pattern so a frame is never mixed
    always_comb begin
        origin        = h_cnt == '0 && v_cnt == '0;
        sel_d         = origin ? pattern_e'(pattern_sel) : sel_q;
        bar           = 3'(h_cnt / 12'(HR / 8));
        pix           = sel_d == PAT_BARS  ? BAR_COLOURS[bar] :
                        sel_d == PAT_GREY  ? {3{h_cnt[10:3]}} :
                        sel_d == PAT_CHECK ? ((h_cnt[6] ^ v_cnt[6]) ? WHITE : BLACK) : WHITE;
        rgb_d         = active ? pix : BLACK;
        de_d          = active;
        hsync_d       = hsync_c;
        vsync_d       = vsync_c;
        frame_start_d = origin;
    end
    always_ff @(posedge pix_1x_clk or posedge reset_in) begin
        if (reset_in) begin
            sel_q         <= PAT_BARS;
            de_q          <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            frame_start_q <= 1'b0;
            rgb_q         <= BLACK;
        end else begin
            sel_q         <= sel_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            rgb_q         <= rgb_d;
        end
    end
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign red_out     = rgb_q[23:16];
    assign green_out   = rgb_q[15:8];
    assign blue_out    = rgb_q[7:0];
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: full-size 1080p instance for line checks, reduced-raster instance for frame checks
module tb_video_pattern_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int failures = 0;
    logic [1:0] rst = 2'b00;
    logic [1:0] psel [2];
    logic [1:0] de, hs, vs, fs;
    logic [7:0] red [2];
    logic [7:0] grn [2];
    logic [7:0] blu [2];

    task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s inst%0d t=%0t got=%h want=%h", nm, inst, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] rgb_of(input int i);
        return {8'h0, red[i], grn[i], blu[i]};
    endfunction

    function automatic logic [23:0] colour(input int h, input int v, input int sel, input int hr);
        logic [23:0] bars [8];
        logic [7:0] g;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        g = 8'((h / 8) % 256);
        case (sel)
            0: return bars[h / (hr / 8)];
            1: return {g, g, g};
            2: return ((h / 64 + v / 64) % 2) ? 24'hFFFFFF : 24'h000000;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g
        localparam int HR  = i == 0 ? 1920 : 128;
        localparam int HFP = i == 0 ? 88 : 8;
        localparam int HSW = i == 0 ? 44 : 4;
        localparam int HBP = i == 0 ? 148 : 4;
        localparam int VR  = i == 0 ? 1080 : 72;
        localparam int VFP = i == 0 ? 4 : 2;
        localparam int VSW = i == 0 ? 5 : 3;
        localparam int VBP = i == 0 ? 36 : 3;
        localparam int HT  = HR + HFP + HSW + HBP;
        localparam int VT  = VR + VFP + VSW + VBP;
        video_pattern_gen #(
            .HR(HR), .HFP(HFP), .HSW(HSW), .HBP(HBP),
            .VR(VR), .VFP(VFP), .VSW(VSW), .VBP(VBP)
        ) dut (
            .pix_1x_clk(clk),
            .reset_in(rst[i]),
            .pattern_sel(psel[i]),
            .de(de[i]),
            .hsync(hs[i]),
            .vsync(vs[i]),
            .frame_start(fs[i]),
            .red_out(red[i]),
            .green_out(grn[i]),
            .blue_out(blu[i])
        );
        int nh = 0, nv = 0, ch = 0, cv = 0, msel = 0;
        bit valid = 1'b0;
        logic on;
        logic [23:0] exp_rgb;
        // (nh,nv) is the next pixel to be shown; (ch,cv) is the pixel on the pins
        always @(posedge clk or posedge rst[i]) begin
            if (rst[i]) begin
                valid <= 1'b0;
                nh <= 0;
                nv <= 0;
                msel <= 0;
            end else begin
                valid <= 1'b1;
                ch <= nh;
                cv <= nv;
                if (nh == 0 && nv == 0) msel <= int'(psel[i]);
                nh <= (nh + 1) % HT;
                if (nh == HT - 1) nv <= (nv + 1) % VT;
            end
        end
        always @(negedge clk) begin
            on = valid && ch < HR && cv < VR;
            exp_rgb = on ? colour(ch, cv, msel, HR) : 24'h0;
            check("de", i, 32'(de[i]), 32'(on));
            check("hsync", i, 32'(hs[i]), 32'(valid && ch >= HR + HFP && ch < HR + HFP + HSW));
            check("vsync", i, 32'(vs[i]), 32'(valid && cv >= VR + VFP && cv < VR + VFP + VSW));
            check("frame_start", i, 32'(fs[i]), 32'(valid && ch == 0 && cv == 0));
            check("rgb", i, rgb_of(i), {8'h0, exp_rgb});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_full();
        int n_de = 0, n_hs = 0;
        step(3);
        check("rst_de", 0, 32'(de[0]), 32'd0);
        check("rst_rgb", 0, rgb_of(0), 32'h0);
        #1 rst[0] = 1'b0;
        step(1);
        check("px0_de", 0, 32'(de[0]), 32'd1);
        check("px0_fs", 0, 32'(fs[0]), 32'd1);
        check("px0_rgb", 0, rgb_of(0), 32'hFFFFFF);
        step(240);
        check("px240_rgb", 0, rgb_of(0), 32'hFFFF00);
        step(1679);
        check("px1919_rgb", 0, rgb_of(0), 32'h000000);
        check("px1919_de", 0, 32'(de[0]), 32'd1);
        step(1);
        check("px1920_de", 0, 32'(de[0]), 32'd0);
        step(87);
        check("px2007_hs", 0, 32'(hs[0]), 32'd0);
        step(1);
        check("px2008_hs", 0, 32'(hs[0]), 32'd1);
        step(43);
        check("px2051_hs", 0, 32'(hs[0]), 32'd1);
        step(1);
        check("px2052_hs", 0, 32'(hs[0]), 32'd0);
        step(148);
        for (int k = 0; k < 2200; k++) begin
            n_de += int'(de[0]);
            n_hs += int'(hs[0]);
            step(1);
        end
        check("line_de_count", 0, 32'(n_de), 32'd1920);
        check("line_hs_count", 0, 32'(n_hs), 32'd44);
        check("line2_fs", 0, 32'(fs[0]), 32'd0);
        step(1000);
        check("midline_de", 0, 32'(de[0]), 32'd1);
        #1 rst[0] = 1'b1;
        psel[0] = 2'd1;
        #1;
        check("rst_mid_de", 0, 32'(de[0]), 32'd0);
        check("rst_mid_rgb", 0, rgb_of(0), 32'h0);
        check("rst_mid_fs", 0, 32'(fs[0]), 32'd0);
        step(2);
        #1 rst[0] = 1'b0;
        step(1);
        check("grey0_fs", 0, 32'(fs[0]), 32'd1);
        check("grey0_rgb", 0, rgb_of(0), 32'h000000);
        step(8);
        check("grey8_rgb", 0, rgb_of(0), 32'h010101);
        step(1911);
        check("grey1919_rgb", 0, rgb_of(0), 32'hEFEFEF);
        step(100);
        check("grey_blank_rgb", 0, rgb_of(0), 32'h000000);
        check("grey_blank_hs", 0, 32'(hs[0]), 32'd1);
    endtask

    task automatic run_small();
        int lines_de = 0, lines_vs = 0, first_vs = -1, n_fs = 0, h, v;
        step(3);
        #1 rst[1] = 1'b0;
        step(1);
        check("s_px0_fs", 1, 32'(fs[1]), 32'd1);
        check("s_px0_rgb", 1, rgb_of(1), 32'hFFFFFF);
        for (int k = 0; k < 11520; k++) begin
            h = k % 144;
            v = k / 144;
            if (h == 0 && de[1]) lines_de++;
            if (h == 0 && vs[1]) begin
                lines_vs++;
                if (first_vs < 0) first_vs = v;
            end
            n_fs += int'(fs[1]);
            if (k == 60 * 144 + 16) check("s_bars_hold", 1, rgb_of(1), 32'hFFFF00);
            if (k == 50 * 144) #1 psel[1] = 2'd2;
            step(1);
        end
        check("s_de_lines", 1, 32'(lines_de), 32'd72);
        check("s_vs_lines", 1, 32'(lines_vs), 32'd3);
        check("s_vs_first", 1, 32'(first_vs), 32'd74);
        check("s_fs_count", 1, 32'(n_fs), 32'd1);
        check("s_f2_fs", 1, 32'(fs[1]), 32'd1);
        check("s_chk_0_0", 1, rgb_of(1), 32'h000000);
        step(64);
        check("s_chk_64_0", 1, rgb_of(1), 32'hFFFFFF);
        step(64 * 144);
        check("s_chk_64_64", 1, rgb_of(1), 32'h000000);
        check("s_chk_64_64_de", 1, 32'(de[1]), 32'd1);
        #1 rst[1] = 1'b1;
        psel[1] = 2'd3;
        #1;
        check("s_rst_de", 1, 32'(de[1]), 32'd0);
        check("s_rst_rgb", 1, rgb_of(1), 32'h0);
        step(2);
        #1 rst[1] = 1'b0;
        step(1);
        check("s_solid_fs", 1, 32'(fs[1]), 32'd1);
        check("s_solid_rgb", 1, rgb_of(1), 32'hFFFFFF);
        step(200);
        check("s_solid_56_1", 1, rgb_of(1), 32'hFFFFFF);
    endtask

    initial begin
        psel[0] = 2'd0;
        psel[1] = 2'd0;
        #1 rst = 2'b11;
        fork
            run_full();
            run_small();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Source end of the pixel-stream interface used by the processing blocks. Generates 1080p60 raster timing (`de`, `hsync`, `vsync`) and a selectable test pattern on separate 8-bit R/G/B outputs. Lets flip and filter stages run on the board without an HDMI input. It sits upstream of those stages in the pix_1x_clk domain.

## Interface
- `HR`, 1920: active pixels per line
- `HFP`, 88: horizontal front porch, clocks
- `HSW`, 44: hsync width, clocks
- `HBP`, 148: horizontal back porch, clocks
- `VR`, 1080: active lines per frame
- `VFP`, 4: vertical front porch, lines
- `VSW`, 5: vsync width, lines
- `VBP`, 36: vertical back porch, lines

Ports:
- `pix_1x_clk` input 1: pixel clock; the only clock
- `reset_in` input 1: reset, asynchronous and active-high
- `pattern_sel` input 2: pattern code (0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid white)
- `de` output 1: active-video enable
- `hsync` output 1: horizontal sync, active-high
- `vsync` output 1: vertical sync, active-high
- `frame_start` output 1: one-cycle pulse marking pixel (0,0)
- `red_out`, `green_out`, `blue_out` output 8 each: pixel colour

## Operation
- Line total is HT = HR+HFP+HSW+HBP (2200). Frame total is VT = VR+VFP+VSW+VBP (1125).
- `h_cnt` runs 0..HT-1 and wraps to 0.
- `v_cnt` increments only when `h_cnt` = HT-1, and wraps from VT-1 to 0.
- Both counters are 12 bits wide.
- Active region: `h_cnt` < HR and `v_cnt` < VR.
- hsync is high when `h_cnt` is in [HR+HFP, HR+HFP+HSW).
- vsync is high when `v_cnt` is in [VR+VFP, VR+VFP+VSW), for the whole line.
- `pattern_sel` is latched into `sel_q` only when `h_cnt`=0 and `v_cnt`=0, so a frame never tears. A change mid-frame takes effect at the next frame.
- Colour bars: bar index = `h_cnt` / (HR/8), giving 240 px per bar. Order is white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- Grey ramp: R=G=B=`h_cnt`[10:3].
- Checkerboard: white if `h_cnt`[6] XOR `v_cnt`[6], else black (64x64 squares).
- Solid: FFFFFF.
- Outside the active region, RGB = 000000 regardless of pattern.
- `frame_start` = 1 exactly when the output pixel is (0,0).

## Timing
- All outputs are registered. Each output reflects the counter state from the previous cycle, so latency is 1 clock from counter to pins.
- In reset, counters and `sel_q` clear to 0. `de`, `hsync`, `vsync`, `frame_start` and RGB reset to 0.
- On the first rising edge after `reset_in` falls:
  - outputs show pixel (0,0): `de`=1, `frame_start`=1;
  - `sel_q` is loaded from `pattern_sel` on that same edge.
- `de` stays high for HR consecutive clocks per active line and low for HT-HR clocks.
- Asserting reset mid-frame immediately zeroes all outputs. On release, timing restarts at (0,0) with no partial line.
- All sync, de and RGB edges are aligned; there is no skew between them.

## Structure
- A shared `video_timing_pkg` holds the 1080p timing constants (HR, HFP, HSW, HBP, VR, VFP, VSW, VBP, HT, VT), the pattern codes, and the 24-bit colour-bar constants. The flip and filter blocks use the same HR/VR.
- One sub-module, `raster_counter`: holds `h_cnt`/`v_cnt`, and produces the active, hsync and vsync decode.
- Pattern colour mapping and output registers stay in the top level.

## Test plan
- Reset release, `pattern_sel`=0:
  - first edge gives `de`=1, `frame_start`=1, RGB=FFFFFF;
  - pixel 240 gives FFFF00;
  - pixel 1919 gives 000000;
  - `de` falls on clock 1920.
- Full line count: `de` high 1920 clocks and low 280 clocks. hsync rises 88 clocks after `de` falls and stays high 44 clocks.
- Full frame:
  - 1080 lines contain `de`;
  - vsync is high for lines 1084..1088;
  - `frame_start` recurs every 2475000 clocks.
- Pattern switch: change `pattern_sel` 0→2 at line 500. Rest of frame stays bars. Next frame: pixel (0,0)=000000, (64,0)=FFFFFF, (64,64)=000000.
- Grey ramp, `pattern_sel`=1: pixel 8 gives 010101, pixel 1919 gives EFEFEF. Blanking gives 000000.
- Reset asserted mid-line (h=1000, v=300): all outputs drop to 0 immediately. After release, `frame_start`=1 on the first edge.
